// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

   // Size of one instruction word in bytes; the fetch PC advances by this.
   localparam int INSTR_BYTES = 4;

   // Default widths used by the entry record below.
   localparam int ADDR_W_DEF  = 32;
   localparam int INSTR_W_DEF = 32;

   // Fetch controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,   // no request, waiting for a free queue slot
      REQ  = 2'd1,   // request outstanding, waiting for data_good
      DROP = 2'd2    // stale request outstanding after a redirect
   } fetch_state_t;

   // One queued instruction together with the address it was fetched from.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0]  addr;
      logic [INSTR_W_DEF-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {address, instruction} entries.
// A synchronous clear wins over push and pop in the same cycle.
module fetch_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_next_s;
   logic              do_push_s;
   logic              do_pop_s;
   logic              empty_s;
   logic              full_s;

   assign empty_s   = (count_r == {CNT_W{1'b0}});
   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign do_push_s = push && !full_s;
   assign do_pop_s  = pop && !empty_s;

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = empty_s;
   assign full  = full_s;

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_next_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_next_s = count_r + CNT_W'(1);
         2'b01:   count_next_s = count_r - CNT_W'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Read/write pointers and occupancy counter; pointers wrap since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (clr) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_next_s;
      end
   end

   // Entry storage; written only on an accepted push outside a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (do_push_s && !clr) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch unit: single-outstanding sequential memory requests,
// a prefetch queue towards decode, and flush/redirect handling.
module instruction_fetch_queue
   import fetch_pkg::*;
#(
   parameter int               ADDR_W   = 32,
   parameter int               INSTR_W  = 32,
   parameter int               DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       instr_fetch,
   output logic [ADDR_W-1:0]          fetch_adr_o,
   input  logic                       data_good,
   input  logic [INSTR_W-1:0]         instruction_i,
   output logic                       instr_valid_o,
   input  logic                       instr_ready_i,
   output logic [INSTR_W-1:0]         instruction_o,
   output logic [ADDR_W-1:0]          instruction_adr_o,
   input  logic                       flush_i,
   input  logic [ADDR_W-1:0]          flush_adr_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int DATA_W = ADDR_W + INSTR_W;

   fetch_state_t      state_r;
   fetch_state_t      state_next_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_next_s;
   logic [ADDR_W-1:0] flush_target_s;
   logic              instr_fetch_r;
   logic              push_s;
   logic              pop_s;
   logic              room_after_push_s;
   logic [DATA_W-1:0] fifo_rdata_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              fifo_empty_s;
   logic              fifo_full_s;

   // Redirect targets are always word aligned.
   assign flush_target_s = flush_adr_i & {{(ADDR_W-2){1'b1}}, 2'b00};

   // A response is only accepted for a live request; a flush discards it.
   assign push_s = (state_r == REQ) && data_good && !flush_i;
   assign pop_s  = !fifo_empty_s && instr_ready_i;

   // In REQ the queue never exceeds DEPTH-1, so a push leaves room unless
   // it fills the last slot without a simultaneous pop.
   assign room_after_push_s = (fifo_count_s != CNT_W'(DEPTH-1)) || pop_s;

   fetch_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush_i),
      .push  (push_s),
      .pop   (pop_s && !flush_i),
      .wdata ({pc_r, instruction_i}),
      .rdata (fifo_rdata_s),
      .count (fifo_count_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   // Next fetch state: flush first, then response handling, then slot availability.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (flush_i) begin
               state_next_s = REQ;
            end else if (!fifo_full_s || pop_s) begin
               state_next_s = REQ;
            end else begin
               state_next_s = IDLE;
            end
         end
         REQ: begin
            if (flush_i) begin
               if (data_good) begin
                  state_next_s = REQ;
               end else begin
                  state_next_s = DROP;
               end
            end else if (data_good) begin
               if (room_after_push_s) begin
                  state_next_s = REQ;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = REQ;
            end
         end
         DROP: begin
            if (flush_i) begin
               state_next_s = DROP;
            end else if (data_good) begin
               state_next_s = REQ;
            end else begin
               state_next_s = DROP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Next fetch PC: redirect on flush, advance one word per accepted response.
   always_comb begin
      pc_next_s = pc_r;
      if (flush_i) begin
         pc_next_s = flush_target_s;
      end else if (push_s) begin
         pc_next_s = pc_r + ADDR_W'(INSTR_BYTES);
      end else begin
         pc_next_s = pc_r;
      end
   end

   // State, PC and request-line registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         pc_r          <= RESET_PC;
         instr_fetch_r <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         pc_r          <= pc_next_s;
         instr_fetch_r <= (state_next_s == REQ);
      end
   end

   assign instr_fetch   = instr_fetch_r;
   assign fetch_adr_o   = pc_r;
   assign instr_valid_o = !fifo_empty_s;
   assign count_o       = fifo_count_s;

   // Head outputs come from queue storage and read as zero when empty.
   always_comb begin
      if (fifo_empty_s) begin
         instruction_o     = {INSTR_W{1'b0}};
         instruction_adr_o = {ADDR_W{1'b0}};
      end else begin
         instruction_o     = fifo_rdata_s[INSTR_W-1:0];
         instruction_adr_o = fifo_rdata_s[DATA_W-1:INSTR_W];
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_instruction_fetch_queue;
   import fetch_pkg::*;

   localparam int          ADDR_W   = 32;
   localparam int          INSTR_W  = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        instr_fetch;
   logic [31:0] fetch_adr_o;
   logic        data_good;
   logic [31:0] instruction_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instruction_o;
   logic [31:0] instruction_adr_o;
   logic        flush_i;
   logic [31:0] flush_adr_i;
   logic [2:0]  count_o;

   int checks = 0;
   int errors = 0;

   // Reference model: queue contents, fetch PC, and whether a memory request
   // is outstanding (m_out) and whether its answer will be thrown away (m_stale).
   fetch_entry_t mq[$];
   logic [31:0]  m_pc;
   bit           m_out;
   bit           m_stale;

   instruction_fetch_queue #(
      .ADDR_W   (ADDR_W),
      .INSTR_W  (INSTR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .instr_fetch       (instr_fetch),
      .fetch_adr_o       (fetch_adr_o),
      .data_good         (data_good),
      .instruction_i     (instruction_i),
      .instr_valid_o     (instr_valid_o),
      .instr_ready_i     (instr_ready_i),
      .instruction_o     (instruction_o),
      .instruction_adr_o (instruction_adr_o),
      .flush_i           (flush_i),
      .flush_adr_i       (flush_adr_i),
      .count_o           (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      m_pc    = RESET_PC;
      m_out   = 1'b0;
      m_stale = 1'b0;
   endtask

   // One clock edge of the architectural behaviour.
   task automatic model_edge(input bit f, input logic [31:0] fa, input bit dg,
                             input logic [31:0] ins, input bit rdy);
      bit           pop;
      fetch_entry_t e;
      pop = (mq.size() != 0) && rdy;
      if (f) begin
         mq.delete();
         m_pc = {fa[31:2], 2'b00};
         if (m_out && (m_stale || !dg)) begin
            m_stale = 1'b1;
         end else begin
            m_out   = 1'b1;
            m_stale = 1'b0;
         end
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_out && m_stale) begin
            if (dg) m_stale = 1'b0;
         end else if (m_out) begin
            if (dg) begin
               e.addr  = m_pc;
               e.instr = ins;
               mq.push_back(e);
               m_pc  = m_pc + 32'd4;
               m_out = (mq.size() < DEPTH);
            end
         end else begin
            m_out = (mq.size() < DEPTH);
         end
      end
   endtask

   // Apply one cycle of inputs, clock, advance the model, settle for sampling.
   task automatic cycle(input bit f, input logic [31:0] fa, input bit dg,
                        input logic [31:0] ins, input bit rdy);
      flush_i       = f;
      flush_adr_i   = fa;
      data_good     = dg;
      instruction_i = ins;
      instr_ready_i = rdy;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(f, fa, dg, ins, rdy);
      #1;
   endtask

   task automatic apply_reset();
      flush_i = 1'b0; flush_adr_i = 32'h0; data_good = 1'b0;
      instruction_i = 32'h0; instr_ready_i = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      flush_i = 1'b0; flush_adr_i = 32'h0; data_good = 1'b0;
      instruction_i = 32'h0; instr_ready_i = 1'b0;
      #1;
      checks++; if (instr_fetch !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %0b want 0", instr_fetch); end
      checks++; if (fetch_adr_o !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", fetch_adr_o, RESET_PC); end
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid_o); end
      checks++; if (instruction_o !== 32'h0 || instruction_adr_o !== 32'h0) begin errors++; $display("FAIL reset_head: got %h/%h want 0/0", instruction_o, instruction_adr_o); end
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
      apply_reset();
      checks++; if (instr_fetch !== 1'b0) begin errors++; $display("FAIL reset_release_fetch: got %0b want 0", instr_fetch); end
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checks++; if (instr_fetch !== 1'b1 || fetch_adr_o !== RESET_PC) begin errors++; $display("FAIL reset_first_req: got %0b@%h want 1@%h", instr_fetch, fetch_adr_o, RESET_PC); end
   endtask

   task automatic test_sequential();
      apply_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++; if (fetch_adr_o !== 32'(4*k)) begin errors++; $display("FAIL seq_req_adr%0d: got %h want %h", k, fetch_adr_o, 32'(4*k)); end
         cycle(1'b0, 32'h0, 1'b1, 32'hA000_0000 + 32'(k), 1'b1);
         checks++; if (instruction_o !== 32'hA000_0000 + 32'(k) || instruction_adr_o !== 32'(4*k)) begin errors++; $display("FAIL seq_head%0d: got %h@%h want %h@%h", k, instruction_o, instruction_adr_o, 32'hA000_0000 + 32'(k), 32'(4*k)); end
         checks++; if (count_o !== 3'd1 || instr_fetch !== 1'b1) begin errors++; $display("FAIL seq_flow%0d: got count %0d fetch %0b want 1 1", k, count_o, instr_fetch); end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 1'b1, 32'hB000_0000 + 32'(k), 1'b0);
      checks++; if (count_o !== 3'd4 || instr_fetch !== 1'b0) begin errors++; $display("FAIL bp_full: got count %0d fetch %0b want 4 0", count_o, instr_fetch); end
      checks++; if (instruction_o !== 32'hB000_0000 || instruction_adr_o !== 32'h0) begin errors++; $display("FAIL bp_head: got %h@%h want b0000000@0", instruction_o, instruction_adr_o); end
      cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      checks++; if (count_o !== 3'd4 || instr_fetch !== 1'b0) begin errors++; $display("FAIL bp_idle_dg: got count %0d fetch %0b want 4 0", count_o, instr_fetch); end
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checks++; if (count_o !== 3'd3 || instr_fetch !== 1'b1 || fetch_adr_o !== 32'h10) begin errors++; $display("FAIL bp_refetch: got count %0d fetch %0b adr %h want 3 1 10", count_o, instr_fetch, fetch_adr_o); end
      checks++; if (instruction_adr_o !== 32'h4 || instruction_o !== 32'hB000_0001) begin errors++; $display("FAIL bp_next_head: got %h@%h want b0000001@4", instruction_o, instruction_adr_o); end
   endtask

   task automatic test_flush_drop();
      apply_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'hC000_0000, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'hC000_0001, 1'b0);
      cycle(1'b1, 32'h103, 1'b0, 32'h0, 1'b0);
      checks++; if (count_o !== 3'd0 || instr_valid_o !== 1'b0 || instruction_o !== 32'h0) begin errors++; $display("FAIL drop_flushq: got count %0d valid %0b instr %h want 0 0 0", count_o, instr_valid_o, instruction_o); end
      checks++; if (instr_fetch !== 1'b0 || fetch_adr_o !== 32'h100) begin errors++; $display("FAIL drop_state: got fetch %0b adr %h want 0 100", instr_fetch, fetch_adr_o); end
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checks++; if (instr_fetch !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL drop_wait: got fetch %0b count %0d want 0 0", instr_fetch, count_o); end
      cycle(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      checks++; if (count_o !== 3'd0 || instr_fetch !== 1'b1 || fetch_adr_o !== 32'h100) begin errors++; $display("FAIL drop_discard: got count %0d fetch %0b adr %h want 0 1 100", count_o, instr_fetch, fetch_adr_o); end
      cycle(1'b0, 32'h0, 1'b1, 32'hC0DE_0001, 1'b0);
      checks++; if (instruction_adr_o !== 32'h100 || instruction_o !== 32'hC0DE_0001 || fetch_adr_o !== 32'h104) begin errors++; $display("FAIL drop_resume: got %h@%h next %h want c0de0001@100 next 104", instruction_o, instruction_adr_o, fetch_adr_o); end
   endtask

   task automatic test_flush_with_data();
      apply_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'h5555_0000, 1'b0);
      cycle(1'b1, 32'h200, 1'b1, 32'hBAD0_BAD0, 1'b0);
      checks++; if (count_o !== 3'd0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL fdg_empty: got count %0d valid %0b want 0 0", count_o, instr_valid_o); end
      checks++; if (instr_fetch !== 1'b1 || fetch_adr_o !== 32'h200) begin errors++; $display("FAIL fdg_req: got fetch %0b adr %h want 1 200", instr_fetch, fetch_adr_o); end
      cycle(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
      checks++; if (instruction_adr_o !== 32'h200 || instruction_o !== 32'h1234_5678 || count_o !== 3'd1) begin errors++; $display("FAIL fdg_first: got %h@%h count %0d want 12345678@200 1", instruction_o, instruction_adr_o, count_o); end
   endtask

   task automatic test_push_pop_same();
      apply_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'hD000_0000, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 32'hD000_0001, 1'b0);
      checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL pp_pre: got %0d want 2", count_o); end
      cycle(1'b0, 32'h0, 1'b1, 32'hD000_0002, 1'b1);
      checks++; if (count_o !== 3'd2 || instruction_adr_o !== 32'h4 || instruction_o !== 32'hD000_0001) begin errors++; $display("FAIL pp_same: got count %0d head %h@%h want 2 d0000001@4", count_o, instruction_o, instruction_adr_o); end
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checks++; if (count_o !== 3'd1 || instruction_adr_o !== 32'h8 || instruction_o !== 32'hD000_0002) begin errors++; $display("FAIL pp_order: got count %0d head %h@%h want 1 d0000002@8", count_o, instruction_o, instruction_adr_o); end
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checks++; if (count_o !== 3'd0 || instruction_o !== 32'h0 || instruction_adr_o !== 32'h0) begin errors++; $display("FAIL pp_drain: got count %0d head %h@%h want 0 0@0", count_o, instruction_o, instruction_adr_o); end
   endtask

   task automatic test_reset_mid_req();
      apply_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1, 32'hE000_0000 + 32'(k), 1'b0);
      data_good = 1'b0;
      checks++; if (count_o !== 3'd3 || instr_fetch !== 1'b1 || fetch_adr_o !== 32'hC) begin errors++; $display("FAIL mrst_pre: got count %0d fetch %0b adr %h want 3 1 c", count_o, instr_fetch, fetch_adr_o); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (count_o !== 3'd0 || instr_valid_o !== 1'b0 || instr_fetch !== 1'b0) begin errors++; $display("FAIL mrst_async: got count %0d valid %0b fetch %0b want 0 0 0", count_o, instr_valid_o, instr_fetch); end
      checks++; if (fetch_adr_o !== RESET_PC || instruction_o !== 32'h0 || instruction_adr_o !== 32'h0) begin errors++; $display("FAIL mrst_outs: got pc %h head %h@%h want %h 0@0", fetch_adr_o, instruction_o, instruction_adr_o, RESET_PC); end
      cycle(1'b0, 32'h0, 1'b1, 32'hEEEE_EEEE, 1'b0);
      rst = 1'b0;
      cycle(1'b0, 32'h0, 1'b1, 32'hEEEE_EEEE, 1'b0);
      checks++; if (count_o !== 3'd0 || instr_fetch !== 1'b1 || fetch_adr_o !== RESET_PC) begin errors++; $display("FAIL mrst_restart: got count %0d fetch %0b adr %h want 0 1 %h", count_o, instr_fetch, fetch_adr_o, RESET_PC); end
      cycle(1'b0, 32'h0, 1'b1, 32'hE100_0000, 1'b0);
      checks++; if (count_o !== 3'd1 || instruction_adr_o !== RESET_PC || instruction_o !== 32'hE100_0000) begin errors++; $display("FAIL mrst_first: got count %0d head %h@%h want 1 e1000000@%h", count_o, instruction_o, instruction_adr_o, RESET_PC); end
   endtask

   task automatic test_random();
      bit          f, dg, rdy;
      logic [31:0] fa, ins, exp_instr, exp_adr;
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         f   = ($urandom_range(0, 19) == 0);
         fa  = $urandom;
         dg  = ($urandom_range(0, 1) == 1);
         ins = $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         cycle(f, fa, dg, ins, rdy);
         exp_instr = (mq.size() != 0) ? mq[0].instr : 32'h0;
         exp_adr   = (mq.size() != 0) ? mq[0].addr  : 32'h0;
         checks++; if (count_o !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count_o, mq.size()); end
         checks++; if (instr_valid_o !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, instr_valid_o, mq.size() != 0); end
         checks++; if (instruction_o !== exp_instr || instruction_adr_o !== exp_adr) begin errors++; $display("FAIL rnd_head c%0d: got %h@%h want %h@%h", c, instruction_o, instruction_adr_o, exp_instr, exp_adr); end
         checks++; if (instr_fetch !== (m_out && !m_stale)) begin errors++; $display("FAIL rnd_fetch c%0d: got %0b want %0b", c, instr_fetch, m_out && !m_stale); end
         checks++; if (fetch_adr_o !== m_pc) begin errors++; $display("FAIL rnd_pc c%0d: got %h want %h", c, fetch_adr_o, m_pc); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sequential();
      test_backpressure();
      test_flush_drop();
      test_flush_with_data();
      test_push_pop_same();
      test_reset_mid_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Parametrised instruction fetch unit with a prefetch queue. It issues sequential word requests to instruction memory with an `instr_fetch`/`data_good` handshake, stores up to `DEPTH` returned instructions with their addresses, and presents them to decode through a valid/ready handshake. Branch redirects flush the queue and restart fetch at a new address. It sits between the memory interface and the decoder.

## Interface
- `ADDR_W`, 32, width of instruction addresses
- `INSTR_W`, 32, width of an instruction word
- `DEPTH`, 4, queue entries; power of two, ≥ 2
- `RESET_PC`, 32'h0, first fetch address after reset; 4-byte aligned

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `instr_fetch`  out  1  memory request outstanding
- `fetch_adr_o`  out  ADDR_W  address of current request
- `data_good`  in  1  memory returns `instruction_i` for current request
- `instruction_i`  in  INSTR_W  returned instruction word
- `instr_valid_o`  out  1  queue head valid
- `instr_ready_i`  in  1  decoder accepts head this cycle
- `instruction_o`  out  INSTR_W  head instruction; 0 when empty
- `instruction_adr_o`  out  ADDR_W  head address; 0 when empty
- `flush_i`  in  1  redirect fetch; discard queue and in-flight data
- `flush_adr_i`  in  ADDR_W  redirect target; bits [1:0] forced to 0
- `count_o`  out  $clog2(DEPTH+1)  valid entries in queue

## Operation
- Reset values: `instr_fetch`=0, `fetch_adr_o`=`RESET_PC`, `instr_valid_o`=0, `instruction_o`=0, `instruction_adr_o`=0, `count_o`=0, state IDLE.
- Reset mid-operation clears the queue and the state immediately. A `data_good` arriving afterwards is ignored.
- At most one request is outstanding at a time.
- Fetch PC increments by 4 on every accepted response, with `ADDR_W` wrap-around.
- FSM states:
  - IDLE, `instr_fetch`=0: go to REQ when `count_o` < `DEPTH`, or when a pop this cycle frees a slot.
  - REQ, `instr_fetch`=1, `fetch_adr_o` held stable:
    - On `data_good`, push {PC, `instruction_i`} and set PC+=4.
    - Stay in REQ (back-to-back request) if the queue is not full after the push and pop. Otherwise go to IDLE.
  - DROP, `instr_fetch`=0: entered when a flush hits REQ without a same-cycle `data_good`. Wait for `data_good`, discard the data, then go to REQ at the redirected PC.
- Flush priority is flush > push > pop. On a `flush_i` edge:
  - Queue emptied, PC set to `flush_adr_i`.
  - From IDLE: go to REQ.
  - From REQ with `data_good`: data discarded, go to REQ.
  - From REQ without `data_good`: go to DROP.
  - From DROP: stay in DROP with the new PC.
- Pop occurs when `instr_valid_o` && `instr_ready_i`. Ready on an empty queue is ignored.
- Push and pop may occur in the same cycle; `count_o` is then unchanged.
- Push never occurs when full, because requests are only issued with a free slot.
- `data_good` is ignored in IDLE.

## Timing
- `instr_fetch` first rises on the first edge after `rst` deasserts.
- Memory response latency is arbitrary; the request is held until `data_good`.
- Push-to-visible latency: 1 cycle. An instruction accepted on edge N appears at the head after edge N if the queue was empty.
- Head outputs are read from registered storage, with no combinational path from `instruction_i`.
- `instr_ready_i` → pop is same-edge. A new head appears after that edge.
- Throughput: 1 instruction/cycle when memory returns `data_good` every cycle and the decoder is always ready.
- After a flush, the first new instruction is visible no earlier than 2 edges later.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` enum (IDLE, REQ, DROP)
  - `INSTR_BYTES` = 4
  - the `fetch_entry_t` struct {addr, instr}, parametrised by the `ADDR_W`/`INSTR_W` defaults
- Sub-module `fetch_fifo`: `DEPTH`-entry circular buffer with pointers, `count`, synchronous clear, and push/pop.
- The top level holds the FSM, the PC and the flush logic.

## Test plan
- Reset, memory answers `data_good` 1 cycle after each request, decoder always ready: addresses 0x0, 0x4, 0x8 are requested; instructions appear in order with matching `instruction_adr_o`.
- Decoder not ready, DEPTH=4: after 4 responses `count_o`=4 and `instr_fetch`=0. One pop → `instr_fetch` re-asserts at 0x10.
- Flush to 0x103 while REQ is pending with `data_good` 3 cycles later: DROP state, stale word discarded, next request at 0x100, queue empty in between.
- `flush_i` and `data_good` in the same cycle: returned word discarded, next `fetch_adr_o`=`flush_adr_i`, `count_o`=0.
- Push and pop in the same cycle at `count_o`=2: count stays 2, order preserved.
- `rst` asserted mid-REQ with 3 entries queued: all outputs at reset values immediately. A late `data_good` causes no push, and fetch restarts at `RESET_PC`.
